// File: rtl/input_sequencer.sv
`timescale 1ns/1ps
// input_sequencer
//   Maps PS/2 keyboard events and joystick bits onto two active-low game
//   input ports, and turns a start request into a timed coin / gap / start
//   pulse sequence measured in video frames.
//
// Ports
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   ps2_key  in   [10] toggle, [9] pressed, [8:0] scan code (bit 8 = extended)
//   joy      in   OR of both joysticks, active-high: [0] R [1] L [2] D [3] U
//                 [4] kick [5] start1 [6] start2
//   horz     in   1 = rotated cabinet orientation, 0 = vertical
//   vblank   in   vertical blank; its rising edge is the frame tick
//   in0      out  active-low {fire,0,0,coin,right,left,down,up}
//   in1      out  active-low {0,start2,start1,5'b0}
//   busy     out  high whenever the coin/start sequencer is not idle
module input_sequencer #(
    parameter int COIN_FRAMES  = 4,
    parameter int GAP_FRAMES   = 8,
    parameter int START_FRAMES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy,
    input  logic        horz,
    input  logic        vblank,
    output logic [7:0]  in0,
    output logic [7:0]  in1,
    output logic        busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COIN    = 3'd1;
    localparam logic [2:0] S_GAP     = 3'd2;
    localparam logic [2:0] S_START   = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    // A zero-length phase is stretched to one frame.
    localparam logic [7:0] COIN_T  = (COIN_FRAMES  == 0) ? 8'd1 : 8'(COIN_FRAMES);
    localparam logic [7:0] GAP_T   = (GAP_FRAMES   == 0) ? 8'd1 : 8'(GAP_FRAMES);
    localparam logic [7:0] START_T = (START_FRAMES == 0) ? 8'd1 : 8'(START_FRAMES);

    logic       key_tog;
    logic       primed;
    logic       key_event;
    logic       key_up, key_down, key_left, key_right, key_fire, key_f1, key_f2;
    logic [8:0] code;
    logic       pressed;

    logic       up, down, left, right, fire, req1, req2, req_any;
    logic       req_q;
    logic       vblank_q;
    logic       tick;

    logic [2:0] state;
    logic [7:0] cnt;
    logic [7:0] cnt_inc;
    logic [7:0] target;
    logic [2:0] next_phase;
    logic       sel;
    logic       coin, start1, start2;

    logic       unused_joy;
    assign unused_joy = ^joy[15:7];

    assign code    = ps2_key[8:0];
    assign pressed = ps2_key[9];
    // The cycle right after reset only captures the toggle bit, so a toggle
    // level that is already set at reset release is not taken as an event.
    assign key_event = primed && (ps2_key[10] != key_tog);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_tog   <= 1'b0;
            primed    <= 1'b0;
            key_up    <= 1'b0;
            key_down  <= 1'b0;
            key_left  <= 1'b0;
            key_right <= 1'b0;
            key_fire  <= 1'b0;
            key_f1    <= 1'b0;
            key_f2    <= 1'b0;
        end else begin
            key_tog <= ps2_key[10];
            primed  <= 1'b1;
            if (key_event) begin
                // Arrows ignore the extended flag; the rest need an exact match.
                if (code[7:0] == 8'h75) key_up    <= pressed;
                if (code[7:0] == 8'h72) key_down  <= pressed;
                if (code[7:0] == 8'h6B) key_left  <= pressed;
                if (code[7:0] == 8'h74) key_right <= pressed;
                if (code == 9'h029 || code == 9'h014) key_fire <= pressed;
                if (code == 9'h005) key_f1 <= pressed;
                if (code == 9'h006) key_f2 <= pressed;
            end
        end
    end

    always_comb begin
        up    = key_up    | joy[3];
        down  = key_down  | joy[2];
        left  = key_left  | joy[1];
        right = key_right | joy[0];
        if (horz) begin
            up    = key_left  | joy[1];
            down  = key_right | joy[0];
            left  = key_down  | joy[2];
            right = key_up    | joy[3];
        end
    end

    assign fire    = key_fire | joy[4];
    assign req1    = key_f1   | joy[5];
    assign req2    = key_f2   | joy[6];
    assign req_any = req1 | req2;

    assign tick = vblank & ~vblank_q;

    always_comb begin
        target     = COIN_T;
        next_phase = S_GAP;
        case (state)
            S_GAP: begin
                target     = GAP_T;
                next_phase = S_START;
            end
            S_START: begin
                target     = START_T;
                next_phase = S_RELEASE;
            end
            default: begin
                target     = COIN_T;
                next_phase = S_GAP;
            end
        endcase
    end

    assign cnt_inc = cnt + 8'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sel      <= 1'b0;
            req_q    <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            vblank_q <= vblank;
            req_q    <= req_any;
            case (state)
                S_IDLE: begin
                    if (req_any && !req_q) begin
                        sel   <= req2 & ~req1;
                        cnt   <= '0;
                        state <= S_COIN;
                    end
                end
                S_COIN, S_GAP, S_START: begin
                    if (tick) begin
                        if (cnt_inc == target) begin
                            cnt   <= '0;
                            state <= next_phase;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                S_RELEASE: begin
                    if (!req1 && !req2) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign coin   = (state == S_COIN);
    assign start1 = (state == S_START) && !sel;
    assign start2 = (state == S_START) && sel;
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in0 <= 8'hFF;
            in1 <= 8'hFF;
        end else begin
            in0 <= ~{fire, 1'b0, 1'b0, coin, right, left, down, up};
            in1 <= ~{1'b0, start2, start1, 5'b0};
        end
    end

endmodule

// File: tb/tb_input_sequencer.sv
`timescale 1ns/1ps
// tb_input_sequencer
//   Directed bench for input_sequencer: key decode, orientation mapping and
//   the frame-timed coin/start sequence, with a second instance whose phase
//   lengths are all zero (each stretched to one frame).
module tb_input_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [15:0] joy;
    logic        horz;
    logic        vblank;
    logic [7:0]  in0, in1;
    logic        busy;
    logic [7:0]  z_in0, z_in1;
    logic        z_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    input_sequencer dut (
        .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key), .joy(joy),
        .horz(horz), .vblank(vblank), .in0(in0), .in1(in1), .busy(busy)
    );

    input_sequencer #(
        .COIN_FRAMES(0), .GAP_FRAMES(0), .START_FRAMES(0)
    ) dut_zero (
        .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key), .joy(joy),
        .horz(horz), .vblank(vblank), .in0(z_in0), .in1(z_in1), .busy(z_busy)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            vblank = 1'b1;
            repeat (4) step();
            vblank = 1'b0;
            repeat (4) step();
        end
    endtask

    // New key event: flip the toggle bit, then wait the two clocks the
    // event needs to reach in0.
    task automatic send_key(input logic prs, input logic [8:0] c);
        ps2_key = {~ps2_key[10], prs, c};
        step();
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        ps2_key = {1'b1, 1'b1, 9'h175};
        joy     = '0;
        horz    = 1'b0;
        vblank  = 1'b0;
        step();
        step();
        check("rst_in0", in0, 8'hFF);
        check("rst_in1", in1, 8'hFF);
        check("rst_busy", {7'd0, busy}, 8'h00);

        // Toggle already high at release must not count as an event.
        reset_n = 1'b1;
        repeat (4) step();
        check("prime_in0", in0, 8'hFF);

        // Extended up arrow, both orientations.
        send_key(1'b1, 9'h175);
        check("up_vert", in0, 8'hFE);
        horz = 1'b1;
        step(); step();
        check("up_horz", in0, 8'hF7);
        horz = 1'b0;
        send_key(1'b0, 9'h175);
        check("up_rel", in0, 8'hFF);

        send_key(1'b1, 9'h129);
        check("ext29_ignored", in0, 8'hFF);
        send_key(1'b0, 9'h129);
        send_key(1'b1, 9'h072);
        check("down_key", in0, 8'hFD);
        send_key(1'b0, 9'h072);
        send_key(1'b1, 9'h16B);
        check("left_ext", in0, 8'hFB);
        send_key(1'b0, 9'h16B);
        send_key(1'b1, 9'h029);
        check("fire_29", in0, 8'h7F);
        send_key(1'b0, 9'h029);
        send_key(1'b1, 9'h014);
        check("fire_14", in0, 8'h7F);
        send_key(1'b0, 9'h014);
        check("fire_rel", in0, 8'hFF);

        // Joystick mapping.
        horz = 1'b1; joy = 16'h0001;
        step(); step();
        check("joy_r_horz", in0, 8'hFD);
        joy = 16'h0008;
        step(); step();
        check("joy_u_horz", in0, 8'hF7);
        horz = 1'b0; joy = 16'h0010;
        step(); step();
        check("joy_fire", in0, 8'h7F);
        joy = 16'h0000;
        step(); step();

        // Full start1 sequence: 4 coin frames, 8 gap, 4 start, then hold.
        joy = 16'h0020;
        step(); step(); step();
        check("seq_coin0", in0, 8'hEF);
        check("seq_busy0", {7'd0, busy}, 8'h01);
        for (int f = 1; f <= 16; f++) begin
            frames(1);
            if (f < 4) begin
                check("seq_coin_in0", in0, 8'hEF);
                check("seq_coin_in1", in1, 8'hFF);
            end else if (f < 12) begin
                check("seq_gap_in0", in0, 8'hFF);
                check("seq_gap_in1", in1, 8'hFF);
            end else if (f < 16) begin
                check("seq_start_in0", in0, 8'hFF);
                check("seq_start_in1", in1, 8'hDF);
            end else begin
                check("seq_rel_in1", in1, 8'hFF);
                check("seq_rel_busy", {7'd0, busy}, 8'h01);
            end
            if (f == 1) check("zero_f1_in1", z_in1, 8'hFF);
            if (f == 2) check("zero_f2_in1", z_in1, 8'hDF);
            if (f == 3) begin
                check("zero_f3_in1", z_in1, 8'hFF);
                check("zero_f3_busy", {7'd0, z_busy}, 8'h01);
            end
        end
        frames(2);
        check("seq_hold_busy", {7'd0, busy}, 8'h01);
        joy = 16'h0000;
        step(); step();
        check("seq_idle_busy", {7'd0, busy}, 8'h00);
        check("zero_idle_busy", {7'd0, z_busy}, 8'h00);

        // Both start buttons on the same clock: start1 wins.
        joy = 16'h0060;
        step(); step(); step();
        frames(12);
        check("both_in1_a", in1, 8'hDF);
        frames(1);
        check("both_in1_b", in1, 8'hDF);
        joy = 16'h0000;
        frames(3);
        step();
        check("both_idle", {7'd0, busy}, 8'h00);

        // start2 with a re-press during GAP: no effect on timing, no queue.
        joy = 16'h0040;
        step(); step(); step();
        frames(5);
        joy = 16'h0000;
        step(); step();
        joy = 16'h0040;
        step();
        frames(7);
        check("s2_in1_a", in1, 8'hBF);
        frames(1);
        check("s2_in1_b", in1, 8'hBF);
        joy = 16'h0000;
        frames(3);
        step();
        check("s2_end_in1", in1, 8'hFF);
        check("s2_end_busy", {7'd0, busy}, 8'h00);
        frames(2);
        check("s2_no_requeue_in0", in0, 8'hFF);
        check("s2_no_requeue_busy", {7'd0, busy}, 8'h00);

        // Start via F2 key.
        send_key(1'b1, 9'h006);
        step();
        check("f2_coin", in0, 8'hEF);
        send_key(1'b0, 9'h006);
        frames(12);
        check("f2_start2", in1, 8'hBF);
        frames(4);
        step();
        check("f2_idle", {7'd0, busy}, 8'h00);

        // Reset mid-COIN.
        joy = 16'h0020;
        step(); step(); step();
        frames(1);
        check("rst_mid_coin", in0, 8'hEF);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_in0", in0, 8'hFF);
        check("rst_async_busy", {7'd0, busy}, 8'h00);
        joy = 16'h0000;
        step(); step();
        reset_n = 1'b1;
        for (int f = 0; f < 6; f++) begin
            frames(1);
            check("post_rst_in0", in0, 8'hFF);
            check("post_rst_busy", {7'd0, busy}, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
